// File: rtl/aes128_key_sched_top.sv
// rtl/aes128_key_sched_top.sv - iterative AES-128 key expansion, one round key per clock
//   clk : rising-edge clock
//   rst : asynchronous active-low reset; clears the round key and restarts the schedule
//   key : 128-bit cipher key, w0 in [127:96] .. w3 in [31:0]; sampled only on the load edge
//   out : registered current round key (round 0 = key, then rounds 1..10, then holds)
module aes128_key_sched_top (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    output logic [127:0] out
);

    logic [127:0] rk;
    logic [3:0]   rnd;
    logic [7:0]   rcon;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0
    // as the S-box requires, then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot, sub, t;
    logic [31:0]  n0, n1, n2, n3;

    always_comb begin
        w0  = rk[127:96];
        w1  = rk[95:64];
        w2  = rk[63:32];
        w3  = rk[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t   = sub ^ {rcon, 24'h000000};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
    end

    // rnd 0: load key; rnd 1..10: expand; rnd 11: done, everything holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk   <= 128'h0;
            rnd  <= 4'd0;
            rcon <= 8'h01;
        end else if (rnd == 4'd0) begin
            rk  <= key;
            rnd <= 4'd1;
        end else if (rnd <= 4'd10) begin
            rk   <= {n0, n1, n2, n3};
            rnd  <= rnd + 4'd1;
            rcon <= xtime(rcon);
        end
    end

    assign out = rk;

endmodule

// File: tb/tb_aes128_key_sched_top.sv
// tb/tb_aes128_key_sched_top.sv - scoreboard bench for aes128_key_sched_top
module tb_aes128_key_sched_top;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic [127:0] out;

    aes128_key_sched_top dut (
        .clk (clk),
        .rst (rst),
        .key (key),
        .out (out)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ALT   = 128'habcdef1212345678aabbccdd11223344;

    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] exp_q[$];
    string        name_q[$];
    event         chk_ev;
    logic [127:0] mdl [0:10];

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = m_xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] c = 8'h63;
        logic [7:0] s;
        for (int b = 1; b < 256; b++)
            if (m_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic build_model(input logic [127:0] k);
        logic [7:0]  rc;
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {m_sbox(tmp[23:16]), m_sbox(tmp[15:8]), m_sbox(tmp[7:0]), m_sbox(tmp[31:24])};
                tmp[31:24] ^= rc;
                rc = m_xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++)
            mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic expect_out(input string name, input logic [127:0] v);
        exp_q.push_back(v);
        name_q.push_back(name);
        -> chk_ev;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] e;
        string        n;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                vectors++;
                if (out !== e) begin
                    miscompares++;
                    $display("FAIL %s: out=%h expected=%h", n, out, e);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b0;
        key = K_FIPS;

        #3 expect_out("rst_noclk_a", 128'h0);
        key = K_ALT;
        #3 expect_out("rst_noclk_b", 128'h0);
        key = '1;
        #3 expect_out("rst_noclk_c", 128'h0);
        vectors++;
        if (out !== 128'h0) begin
            miscompares++;
            $display("FAIL rst_state_direct: out=%h expected=0", out);
        end
        clk_en = 1'b1;
        #30 expect_out("rst_clocked", 128'h0);

        build_model(K_FIPS);
        @(negedge clk);
        key = K_FIPS;
        rst = 1'b1;
        tick(); expect_out("fips_r0", K_FIPS);
        tick(); expect_out("fips_r1", 128'ha0fafe1788542cb123a339392a6c7605);
        tick(); expect_out("fips_r2", 128'hf2c295f27a96b9435935807a7359f67f);
        for (int r = 3; r <= 9; r++) begin
            tick(); expect_out($sformatf("fips_r%0d", r), mdl[r]);
        end
        tick(); expect_out("fips_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int i = 0; i < 6; i++) begin
            tick(); expect_out($sformatf("fips_hold%0d", i), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end

        @(negedge clk);
        rst = 1'b0;
        #1 expect_out("rst_between", 128'h0);
        build_model(K_ALT);
        @(negedge clk);
        key = K_ALT;
        rst = 1'b1;
        tick(); expect_out("alt_r0", K_ALT);
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            key = {$urandom, $urandom, $urandom, $urandom};
            tick(); expect_out($sformatf("alt_r%0d", r), mdl[r]);
        end
        tick(); expect_out("alt_hold", mdl[10]);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        key = K_FIPS;
        build_model(K_FIPS);
        rst = 1'b1;
        for (int r = 0; r <= 5; r++) begin
            tick(); expect_out($sformatf("pre_abort_r%0d", r), mdl[r]);
        end
        #2 rst = 1'b0;
        #1 expect_out("abort_async", 128'h0);
        key = 128'h0;
        build_model(128'h0);
        tick(); expect_out("abort_held", 128'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(); expect_out("zero_r0", 128'h0);
        tick(); expect_out("zero_r1", 128'h62636363626363636263636362636363);
        tick(); expect_out("zero_r2", 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        for (int r = 3; r <= 9; r++) begin
            tick(); expect_out($sformatf("zero_r%0d", r), mdl[r]);
        end
        wait_cyc = 0;
        while (out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        vectors++;
        if (out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            miscompares++;
            $display("FAIL zero_r10_wait: timed out after %0d cycles, out=%h", wait_cyc, out);
        end
        expect_out("zero_r10", 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        for (int i = 0; i < 5; i++) begin
            tick(); expect_out($sformatf("zero_hold%0d", i), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        end

        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0 || vectors < 12)
            $display("FAIL: %0d miscompares over %0d vectors", miscompares, vectors);
        else
            $display("PASS");
        $finish;
    end

endmodule
